alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execution-stage ALU that consumes the 4-bit `alu_control` code produced by the ALU control decoder and performs the selected operation on two 32-bit operands. Single-cycle ops (logic, add/sub, slt, shifts, lui) are combinational. `mult`/`div` run on an iterative multi-cycle engine that writes the HI/LO registers and drives a busy/done handshake; the pipeline stalls on `busy`.

## Interface
- `WIDTH`, 32: operand/result width; iteration count of the mult/div engine.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `alu_control`  in  4  operation code (encoding in Operation).
- `a`  in  WIDTH  operand A (rs).
- `b`  in  WIDTH  operand B (rt or immediate).
- `shamt`  in  5  shift amount.
- `valid_in`  in  1  operation valid this cycle; qualifies mult/div start.
- `result`  out  WIDTH  combinational result of single-cycle ops.
- `zero`  out  1  `result == 0`.
- `busy`  out  1  mult/div engine not idle.
- `done`  out  1  one-cycle pulse when HI/LO are updated.
- `hi`  out  WIDTH  HI register (product high / remainder).
- `lo`  out  WIDTH  LO register (product low / quotient).

## Operation
- Encoding:
  - 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 0100 xor, 1100 nor;
  - 1101 sll, 0101 srl, 1110 sra (shift `b` by `shamt`);
  - 1111 lui (`b << 16`);
  - 1001 mult, 1010 div.
  - 0011, 1000, 1011 and the mult/div codes give `result` = 0.
- add/sub wrap modulo 2^WIDTH, no overflow trap. slt is a signed compare; result 1 or 0.
- Single-cycle ops are always evaluated, including while `busy`.
- mult: signed. The engine multiplies magnitudes with shift-add and negates the 2·WIDTH product if the operand signs differ. HI = upper half, LO = lower half.
- div: signed restoring division on magnitudes.
  - Quotient truncates toward zero and goes to LO.
  - Remainder takes the sign of the dividend and goes to HI.
- Divide by zero (`b` = 0 at accept): LO = all ones, HI = `a`. Completes via the short path below.
- Start condition: `valid_in` && code ∈ {1001, 1010} && state IDLE. The engine latches `a`, `b` and the opcode.
- Start requests while not IDLE are ignored.
- FSM:
  - IDLE → RUN on start, count = 0. IDLE → FIX directly on a divide by zero.
  - RUN: one iteration per cycle; RUN → FIX after WIDTH iterations.
  - FIX: sign correction, HI/LO write, `done` = 1; FIX → IDLE.
- `busy` = (state != IDLE). `done` is registered and high for exactly the cycle after the FIX edge.
- Reset values: state IDLE, `hi` = 0, `lo` = 0, `done` = 0, `busy` = 0. `result` and `zero` follow inputs.
- Reset asserted mid-operation aborts the operation. HI/LO clear and no `done` is issued.

## Timing
- Single-cycle ops: 0 latency, combinational from `alu_control`, `a`, `b`, `shamt`.
- Normal mult/div, with the accept edge called E0:
  - `busy` is high from after E0 through E(WIDTH+1).
  - HI/LO update at E(WIDTH+1); `done` is high between E(WIDTH+1) and E(WIDTH+2).
  - `busy` is low while `done` is high, so a new start is accepted on the `done` cycle.
- Divide by zero: HI/LO update at E1; `done` is high for the cycle after E1.
- HI/LO hold their values between completions.

## Structure
- Package `alu_pkg`:
  - localparams for all 13 `alu_control` codes;
  - enum `muldiv_state_t` {IDLE, RUN, FIX};
  - `WIDTH` default.
- Sub-module `muldiv_unit`: FSM, iteration counter, shift/accumulate datapath, sign fix, HI/LO registers, `busy`/`done`.
- The top level holds the combinational op mux and the `zero` flag, and instantiates `muldiv_unit`.

## Test plan
- Combinational ops:
  - sra, `b` = 0x80000000, `shamt` = 4 → `result` 0xF8000000;
  - slt, `a` = 0xFFFFFFFF, `b` = 1 → 1;
  - lui, `b` = 0x00001234 → 0x12340000;
  - sub, `a` = `b` = 5 → `result` 0, `zero` = 1.
- mult, `a` = -3, `b` = 7 → HI 0xFFFFFFFF, LO 0xFFFFFFEB; `done` in the cycle after edge 33; `busy` low in the `done` cycle.
- div, `a` = -7, `b` = 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. Then div, `a` = 5, `b` = 0 → LO 0xFFFFFFFF, HI 5, `done` one cycle after accept.
- Second mult start asserted while `busy` → ignored; HI/LO reflect only the first operation, and exactly one `done` pulse.
- Start mult, deassert `rst_n` at iteration 10 → `busy`, `done` = 0 and HI/LO = 0 immediately. After release, a new div 100/7 → LO 14, HI 2.
- Back-to-back: start a new mult on the `done` cycle of the previous one → accepted; completes WIDTH+1 edges later.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the execution-stage ALU: default operand width,
//   the alu_control operation codes and the mult/div engine state type.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLL  = 4'b1101;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;
  localparam logic [3:0] ALU_LUI  = 4'b1111;
  localparam logic [3:0] ALU_MULT = 4'b1001;
  localparam logic [3:0] ALU_DIV  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative signed multiply / divide engine writing the HI/LO registers.
//   Works on operand magnitudes (shift-add multiply, restoring divide) and
//   applies the sign correction in the final FIX cycle.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; operands latched on accept
//   RUN   | one shift-add / restoring-divide iteration per cycle
//   FIX   | sign correction, HI/LO write, done pulse issued next cycle
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request (already qualified by valid_in and opcode)
//   op_div      1 = divide, 0 = multiply
//   a, b        operands (a = multiplicand/dividend, b = multiplier/divisor)
//   busy        engine not idle
//   done        one-cycle pulse after HI/LO are written
//   hi, lo      HI (product high / remainder), LO (product low / quotient)
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  muldiv_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier then product low / dividend then quotient
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic             is_div;
  logic             neg_q;    // product or quotient must be negated
  logic             neg_r;    // remainder must be negated (dividend negative)

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic [2*WIDTH-1:0] prod_raw, prod_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

  always_comb begin
    mul_sum = {1'b0, acc_hi};
    if (acc_lo[0]) mul_sum = {1'b0, acc_hi} + {1'b0, opnd};

    // Restoring step: bring in the next dividend bit, keep the difference
    // only when it did not go negative.
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (!div_diff[WIDTH]) begin
      div_rem = div_diff[WIDTH-1:0];
      div_quo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      div_rem = div_shift[WIDTH-1:0];
      div_quo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_raw = {acc_hi, acc_lo};
    prod_neg = ~prod_raw + (2*WIDTH)'(1);
    fix_hi   = '0;
    fix_lo   = '0;
    if (is_div) begin
      fix_hi = neg_r ? (~acc_hi + WIDTH'(1)) : acc_hi;
      fix_lo = neg_q ? (~acc_lo + WIDTH'(1)) : acc_lo;
    end else if (neg_q) begin
      fix_hi = prod_neg[2*WIDTH-1:WIDTH];
      fix_lo = prod_neg[WIDTH-1:0];
    end else begin
      fix_hi = prod_raw[2*WIDTH-1:WIDTH];
      fix_lo = prod_raw[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op_div;
            cnt    <= '0;
            if (op_div && (b == '0)) begin
              // Divide by zero skips RUN; FIX then passes these through unchanged.
              acc_hi <= a;
              acc_lo <= '1;
              opnd   <= '0;
              neg_q  <= 1'b0;
              neg_r  <= 1'b0;
              state  <= FIX;
            end else begin
              acc_hi <= '0;
              acc_lo <= a_mag;
              opnd   <= b_mag;
              neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r  <= a[WIDTH-1];
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            acc_hi <= div_rem;
            acc_lo <= div_quo;
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execution-stage ALU. Single-cycle operations are a combinational mux
//   that is always evaluated; mult/div are handed to muldiv_unit, which
//   owns HI/LO and the busy/done handshake.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   alu_control  4-bit operation code
//   a, b         operands (rs, rt/immediate)
//   shamt        shift amount for sll/srl/sra
//   valid_in     qualifies a mult/div start
//   result, zero combinational result and result==0 flag
//   busy, done   mult/div engine handshake
//   hi, lo       HI/LO registers
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  input  logic             valid_in,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic is_mult, is_div, start;

  assign is_mult = (alu_control == ALU_MULT);
  assign is_div  = (alu_control == ALU_DIV);
  assign start   = valid_in && (is_mult || is_div);

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      ALU_SRA: result = $signed(b) >>> shamt;
      ALU_LUI: result = b << 16;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_div (is_div),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   alu_control = 4'b0000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [4:0]   shamt = '0;
  logic         valid_in = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_chk = 0;
  int n_err = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .shamt       (shamt),
    .valid_in    (valid_in),
    .result      (result),
    .zero        (zero),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic comb(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic [4:0] sh,
                      input logic [W-1:0] exp_res, input logic exp_zero);
    alu_control = op;
    a = av;
    b = bv;
    shamt = sh;
    #1;
    chk(tag, result, exp_res);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_zero});
  endtask

  // Drives a start for one edge (the accept edge E0); returns 1 time unit after E0.
  task automatic start_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    alu_control = op;
    a = av;
    b = bv;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  // Steps until done is seen (bounded); lat = edges stepped.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  int lat;
  int n_done;

  initial begin
    repeat (3) step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    step();

    // Combinational ops
    comb("sra",   ALU_SRA, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
    comb("slt",   ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0);
    comb("slt_n", ALU_SLT, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1);
    comb("lui",   ALU_LUI, 32'h0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0);
    comb("sub",   ALU_SUB, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1);
    comb("addwr", ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1);
    comb("and",   ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 1'b0);
    comb("nor",   ALU_NOR, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 32'h0F0F_F0F0, 1'b0);
    comb("xor",   ALU_XOR, 32'hFFFF_0000, 32'hFF00_FF00, 5'd0, 32'h00FF_FF00, 1'b0);
    comb("sll",   ALU_SLL, 32'h0, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0);
    comb("srl",   ALU_SRL, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
    comb("rsvd",  4'b0011, 32'h1234, 32'h5678, 5'd0, 32'h0, 1'b1);
    comb("multc", ALU_MULT, 32'h1234, 32'h5678, 5'd0, 32'h0, 1'b1);

    // mult -3 * 7
    start_op(ALU_MULT, 32'hFFFF_FFFD, 32'd7);
    chk("mul_busy0", {31'b0, busy}, 32'd1);
    wait_done(lat);
    chk("mul_lat", lat, 32'd33);
    chk("mul_busy_done", {31'b0, busy}, 32'd0);
    chk("mul_hi", hi, 32'hFFFF_FFFF);
    chk("mul_lo", lo, 32'hFFFF_FFEB);
    step();
    chk("mul_done_end", {31'b0, done}, 32'd0);
    comb("busy_comb", ALU_OR, 32'h1, 32'h2, 5'd0, 32'h3, 1'b0);

    // div -7 / 2
    start_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    chk("div_lat", lat, 32'd33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    step();

    // div 5 / 0
    start_op(ALU_DIV, 32'd5, 32'd0);
    wait_done(lat);
    chk("dz_lat", lat, 32'd1);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd5);
    step();
    chk("dz_busy_after", {31'b0, busy}, 32'd0);

    // Second start while busy is ignored
    start_op(ALU_MULT, 32'hFFFF_FFFD, 32'd7);
    repeat (4) step();
    a = 32'd2;
    b = 32'd2;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("ign_hold_hi", hi, 32'd5);
    wait_done(lat);
    chk("ign_lat", lat, 32'd28);
    chk("ign_hi", hi, 32'hFFFF_FFFF);
    chk("ign_lo", lo, 32'hFFFF_FFEB);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) n_done++;
    end
    chk("ign_extra_done", n_done, 32'd0);
    chk("ign_hold_lo", lo, 32'hFFFF_FFEB);

    // Reset during iteration 10
    start_op(ALU_MULT, 32'd6, 32'd7);
    repeat (10) step();
    chk("rstm_busy_pre", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstm_busy", {31'b0, busy}, 32'd0);
    chk("rstm_done", {31'b0, done}, 32'd0);
    chk("rstm_hi", hi, 32'd0);
    chk("rstm_lo", lo, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    start_op(ALU_DIV, 32'd100, 32'd7);
    wait_done(lat);
    chk("d100_lat", lat, 32'd33);
    chk("d100_lo", lo, 32'd14);
    chk("d100_hi", hi, 32'd2);

    // Back-to-back: mult 6*7, then new mult on its done cycle
    step();
    start_op(ALU_MULT, 32'd6, 32'd7);
    wait_done(lat);
    chk("b2b1_lat", lat, 32'd33);
    chk("b2b1_lo", lo, 32'd42);
    chk("b2b1_hi", hi, 32'd0);
    start_op(ALU_MULT, 32'd1000, 32'hFFFF_FFFB);
    chk("b2b2_busy", {31'b0, busy}, 32'd1);
    wait_done(lat);
    chk("b2b2_lat", lat, 32'd33);
    chk("b2b2_hi", hi, 32'hFFFF_FFFF);
    chk("b2b2_lo", lo, 32'hFFFF_EC78);
    step();
    chk("b2b2_done_end", {31'b0, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
